// File: rtl/img_frame_src_pkg.sv
// rtl/img_frame_src_pkg.sv - shared state encoding and default timing for the image frame source
package img_frame_src_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_VS_LEAD    = 3'd1,
        ST_LINE_ACT   = 3'd2,
        ST_LINE_BLANK = 3'd3,
        ST_VS_TAIL    = 3'd4,
        ST_FRAME_GAP  = 3'd5
    } img_state_e;

    localparam int DEF_H_ACT   = 800;
    localparam int DEF_V_ACT   = 600;
    localparam int DEF_H_BLANK = 160;
    localparam int DEF_V_LEAD  = 10;
    localparam int DEF_V_TAIL  = 10;
    localparam int DEF_F_GAP   = 20;
    localparam int DEF_ADDR_W  = 20;

    // Largest of four phase lengths; sizes the shared phase counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/img_timing_gen.sv
// rtl/img_timing_gen.sv - frame/line timing FSM producing fetch-stage vsync, href, busy and frame_done
module img_timing_gen
    import img_frame_src_pkg::*;
#(
    parameter int H_ACT   = DEF_H_ACT,
    parameter int V_ACT   = DEF_V_ACT,
    parameter int H_BLANK = DEF_H_BLANK,
    parameter int V_LEAD  = DEF_V_LEAD,
    parameter int V_TAIL  = DEF_V_TAIL,
    parameter int F_GAP   = DEF_F_GAP
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       cont_i,
    output img_state_e state_o,
    output logic       vsync_o,
    output logic       href_o,
    output logic       busy_o,
    output logic       frame_done_o
);

    localparam int PIX_W  = $clog2(H_ACT + 1);
    localparam int LINE_W = $clog2(V_ACT + 1);
    localparam int PH_W   = $clog2(max4(V_LEAD, H_BLANK, V_TAIL, F_GAP) + 1);

    localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(H_ACT - 1);
    localparam logic [LINE_W-1:0] LINE_NUM   = LINE_W'(V_ACT);
    localparam logic [PH_W-1:0]   LEAD_LAST  = PH_W'(V_LEAD - 1);
    localparam logic [PH_W-1:0]   BLANK_LAST = PH_W'(H_BLANK - 1);
    localparam logic [PH_W-1:0]   TAIL_LAST  = PH_W'(V_TAIL - 1);
    localparam logic [PH_W-1:0]   GAP_LAST   = PH_W'(F_GAP - 1);

    img_state_e        state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [LINE_W-1:0] line_q, line_d;

    // State and counter registers; reset aborts any frame in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            pix_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
        end
    end

    // Next-state, counter updates and fetch-stage outputs.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        pix_d        = pix_q;
        line_d       = line_q;
        frame_done_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_VS_LEAD;
                    phase_d = '0;
                end
            end
            ST_VS_LEAD: begin
                if (phase_q == LEAD_LAST) begin
                    state_d = ST_LINE_ACT;
                    phase_d = '0;
                    pix_d   = '0;
                    line_d  = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_LINE_ACT: begin
                // Line count is bumped as the line finishes, so it reads
                // "lines completed" during the following blank.
                if (pix_q == PIX_LAST) begin
                    state_d = ST_LINE_BLANK;
                    pix_d   = '0;
                    line_d  = line_q + 1'b1;
                    phase_d = '0;
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
            ST_LINE_BLANK: begin
                if (phase_q == BLANK_LAST) begin
                    phase_d = '0;
                    state_d = (line_q < LINE_NUM) ? ST_LINE_ACT : ST_VS_TAIL;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_VS_TAIL: begin
                if (phase_q == TAIL_LAST) begin
                    state_d = ST_FRAME_GAP;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_FRAME_GAP: begin
                if (phase_q == GAP_LAST) begin
                    frame_done_o = 1'b1;
                    phase_d      = '0;
                    state_d      = cont_i ? ST_VS_LEAD : ST_IDLE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign state_o = state_q;
    assign vsync_o = (state_q == ST_VS_LEAD) || (state_q == ST_LINE_ACT) ||
                     (state_q == ST_LINE_BLANK) || (state_q == ST_VS_TAIL);
    assign href_o  = (state_q == ST_LINE_ACT);
    assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: rtl/img_frame_src.sv
// rtl/img_frame_src.sv - frame source: timing FSM, frame-store read port and output alignment stage
module img_frame_src
    import img_frame_src_pkg::*;
#(
    parameter int H_ACT   = DEF_H_ACT,
    parameter int V_ACT   = DEF_V_ACT,
    parameter int H_BLANK = DEF_H_BLANK,
    parameter int V_LEAD  = DEF_V_LEAD,
    parameter int V_TAIL  = DEF_V_TAIL,
    parameter int F_GAP   = DEF_F_GAP,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    output logic              busy,
    output logic              frame_done,
    output logic              pix_rd_en,
    output logic [ADDR_W-1:0] pix_rd_addr,
    input  logic [7:0]        pix_rd_data,
    output logic              img_vsync,
    output logic              img_href,
    output logic [7:0]        img_gray
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACT * V_ACT - 1);

    img_state_e        state;
    logic              vsync_f;
    logic              href_f;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              vsync_q, href_q;

    img_timing_gen #(
        .H_ACT   (H_ACT),
        .V_ACT   (V_ACT),
        .H_BLANK (H_BLANK),
        .V_LEAD  (V_LEAD),
        .V_TAIL  (V_TAIL),
        .F_GAP   (F_GAP)
    ) u_timing (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .cont_i       (cont),
        .state_o      (state),
        .vsync_o      (vsync_f),
        .href_o       (href_f),
        .busy_o       (busy),
        .frame_done_o (frame_done)
    );

    // Address is cleared throughout VS_LEAD and saturates at the last pixel
    // so it never wraps or overruns the frame store.
    always_comb begin
        addr_d = addr_q;
        if (state == ST_VS_LEAD) begin
            addr_d = '0;
        end else if (href_f && (addr_q != ADDR_LAST)) begin
            addr_d = addr_q + 1'b1;
        end
    end

    // Address register and one-cycle sync delay matching the store's read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            vsync_q <= vsync_f;
            href_q  <= href_f;
        end
    end

    assign pix_rd_en   = href_f;
    assign pix_rd_addr = addr_q;
    assign img_vsync   = vsync_q;
    assign img_href    = href_q;
    assign img_gray    = href_q ? pix_rd_data : 8'h00;

endmodule

// File: tb/tb_img_frame_src.sv
// tb/tb_img_frame_src.sv - directed self-checking bench for img_frame_src
module tb_img_frame_src;

    localparam int H_ACT   = 4;
    localparam int V_ACT   = 3;
    localparam int H_BLANK = 2;
    localparam int V_LEAD  = 2;
    localparam int V_TAIL  = 2;
    localparam int F_GAP   = 3;
    localparam int ADDR_W  = 8;
    localparam int FRAME   = 25;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              cont = 1'b0;
    logic              busy;
    logic              frame_done;
    logic              pix_rd_en;
    logic [ADDR_W-1:0] pix_rd_addr;
    logic [7:0]        pix_rd_data = 8'h00;
    logic              img_vsync;
    logic              img_href;
    logic [7:0]        img_gray;

    int n_checks = 0;
    int n_fails  = 0;

    img_frame_src #(
        .H_ACT   (H_ACT),
        .V_ACT   (V_ACT),
        .H_BLANK (H_BLANK),
        .V_LEAD  (V_LEAD),
        .V_TAIL  (V_TAIL),
        .F_GAP   (F_GAP),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cont        (cont),
        .busy        (busy),
        .frame_done  (frame_done),
        .pix_rd_en   (pix_rd_en),
        .pix_rd_addr (pix_rd_addr),
        .pix_rd_data (pix_rd_data),
        .img_vsync   (img_vsync),
        .img_href    (img_href),
        .img_gray    (img_gray)
    );

    always #5 clk = ~clk;

    // Frame store: 1-cycle latency, data = addr+1; junk when not read.
    always @(posedge clk) pix_rd_data <= pix_rd_en ? 8'(pix_rd_addr + 8'd1) : 8'h5A;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle c of a frame (c=0 is the first VS_LEAD cycle): is it a fetch pixel?
    function automatic bit f_act(input int c);
        if (c < 2 || c > 19) return 1'b0;
        return ((c - 2) % 6) < 4;
    endfunction

    function automatic int f_idx(input int c);
        return ((c - 2) / 6) * 4 + ((c - 2) % 6);
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_frame(input string name, input int ncyc, input int start_c,
                             input int cont_drop_c, input int rst_c,
                             output int rd_cnt, output int href_cnt, output int done_cnt);
        rd_cnt = 0; href_cnt = 0; done_cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            chk($sformatf("%s busy c%0d", name, c), busy, 1);
            chk($sformatf("%s rd_en c%0d", name, c), pix_rd_en, f_act(c));
            if (f_act(c)) chk($sformatf("%s addr c%0d", name, c), pix_rd_addr, f_idx(c));
            chk($sformatf("%s done c%0d", name, c), frame_done, (c == FRAME - 1));
            chk($sformatf("%s vsync c%0d", name, c), img_vsync, (c >= 1 && c <= 22));
            chk($sformatf("%s href c%0d", name, c), img_href, f_act(c - 1));
            chk($sformatf("%s gray c%0d", name, c), img_gray,
                f_act(c - 1) ? f_idx(c - 1) + 1 : 0);
            rd_cnt   += int'(pix_rd_en);
            href_cnt += int'(img_href);
            done_cnt += int'(frame_done);
            start = (c == start_c);
            if (c == cont_drop_c) cont = 1'b0;
            if (c == rst_c) rst = 1'b1;
        end
    endtask

    task automatic idle_after(input string name);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk({name, " idle busy"}, busy, 0);
        chk({name, " idle done"}, frame_done, 0);
        chk({name, " idle rd_en"}, pix_rd_en, 0);
        chk({name, " idle vsync"}, img_vsync, 0);
        chk({name, " idle href"}, img_href, 0);
        chk({name, " idle addr_max"}, (pix_rd_addr <= 8'd11), 1);
    endtask

    task automatic chk_zero(input string name);
        chk({name, " busy"}, busy, 0);
        chk({name, " done"}, frame_done, 0);
        chk({name, " rd_en"}, pix_rd_en, 0);
        chk({name, " addr"}, pix_rd_addr, 0);
        chk({name, " vsync"}, img_vsync, 0);
        chk({name, " href"}, img_href, 0);
        chk({name, " gray"}, img_gray, 0);
    endtask

    initial begin
        int rd, hr, dn;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("idle_nostart");

        // Single frame
        pulse_start();
        run_frame("single", FRAME, -1, -1, -1, rd, hr, dn);
        chk("single rd_cnt", rd, 12);
        chk("single href_cnt", hr, 12);
        chk("single done_cnt", dn, 1);
        idle_after("single");

        // start during LINE_ACT ignored
        pulse_start();
        run_frame("restart_act", FRAME, 3, -1, -1, rd, hr, dn);
        chk("restart_act done_cnt", dn, 1);
        idle_after("restart_act");

        // start on last FRAME_GAP cycle ignored
        pulse_start();
        run_frame("start_lastgap", FRAME, FRAME - 1, -1, -1, rd, hr, dn);
        idle_after("start_lastgap");

        // Continuous frames, cont dropped mid third frame
        cont = 1'b1;
        pulse_start();
        run_frame("cont1", FRAME, -1, -1, -1, rd, hr, dn);
        chk("cont1 done_cnt", dn, 1);
        run_frame("cont2", FRAME, -1, -1, -1, rd, hr, dn);
        chk("cont2 rd_cnt", rd, 12);
        run_frame("cont3", FRAME, -1, 10, -1, rd, hr, dn);
        chk("cont3 done_cnt", dn, 1);
        idle_after("cont3");

        // Reset on 2nd pixel of line 2
        pulse_start();
        run_frame("midrst", 10, -1, -1, 9, rd, hr, dn);
        @(negedge clk);
        chk_zero("midrst after");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("midrst idle busy %0d", i), busy, 0);
            chk($sformatf("midrst idle done %0d", i), frame_done, 0);
        end
        pulse_start();
        run_frame("postrst", FRAME, -1, -1, -1, rd, hr, dn);
        chk("postrst rd_cnt", rd, 12);
        chk("postrst done_cnt", dn, 1);
        idle_after("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
